// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that shares one 8N1 UART transmit line
// between NUM_REQ byte requesters. One requester is granted per frame, and the
// granted byte is latched, so requester inputs may change freely during a frame.
module uart_tx_arbiter #(
  parameter int SYSTEM_CLK     = 50000000,
  parameter int UART_BUAD_RATE = 9600,
  parameter int NUM_REQ        = 4
) (
  input  logic                       i_sys_clk,
  input  logic                       i_rst_n,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [NUM_REQ*8-1:0]       i_req_data,
  output logic [NUM_REQ-1:0]         o_req_ready,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
  output logic                       o_busy,
  output logic                       o_uart_tx
);

  localparam int DIVIDER = SYSTEM_CLK / UART_BUAD_RATE;
  localparam int ID_W    = $clog2(NUM_REQ);
  localparam int CNT_W   = $clog2(DIVIDER);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e            state_q;
  logic [7:0]        shift_q;
  logic [2:0]        bit_idx_q;
  logic [CNT_W-1:0]  baud_cnt_q;
  logic [ID_W-1:0]   last_grant_q;
  logic [ID_W-1:0]   grant_id_q;
  logic              busy_q;
  logic              tx_q;

  logic [ID_W-1:0]   winner;
  logic [ID_W-1:0]   cand;
  logic              found;
  logic              baud_tick;
  logic [7:0]        req_byte [NUM_REQ];

  // Unpacked view of the requester bytes so the winner can index them directly.
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_bytes
    assign req_byte[k] = i_req_data[8*k +: 8];
  end

  assign baud_tick = (baud_cnt_q == CNT_W'(DIVIDER - 1));

  // Round-robin search: first valid requester starting just after the last grant.
  always_comb begin
    winner = last_grant_q;
    cand   = '0;
    found  = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ID_W'((int'(last_grant_q) + i) % NUM_REQ);
      if (!found && i_req_valid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // One-hot accept strobe, only in IDLE, only for a valid requester, never in reset.
  always_comb begin
    o_req_ready = '0;
    if (state_q == IDLE && found && i_rst_n) begin
      o_req_ready[winner] = 1'b1;
    end
  end

  // Frame sequencer: grant, start bit, 8 data bits LSB first, stop bit.
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_idx_q    <= '0;
      baud_cnt_q   <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      grant_id_q   <= '0;
      busy_q       <= 1'b0;
      tx_q         <= 1'b1;
    end else begin
      // Baud counter free-runs with wrap whenever a frame is in progress.
      if (state_q != IDLE) begin
        baud_cnt_q <= baud_tick ? '0 : baud_cnt_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (found) begin
            shift_q      <= req_byte[winner];
            last_grant_q <= winner;
            grant_id_q   <= winner;
            baud_cnt_q   <= '0;
            bit_idx_q    <= '0;
            tx_q         <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= START;
          end
        end
        START: begin
          if (baud_tick) begin
            bit_idx_q <= '0;
            tx_q      <= shift_q[0];
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (baud_tick) begin
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shift_q[bit_idx_q + 3'd1];
            end
          end
        end
        STOP: begin
          if (baud_tick) begin
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_grant_id = grant_id_q;
  assign o_busy     = busy_q;
  assign o_uart_tx  = tx_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with DIVIDER = 16 and four requesters.
module tb_uart_tx_arbiter;

  localparam int NR  = 4;
  localparam int DIV = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] valid;
  logic [NR*8-1:0] data;
  logic [NR-1:0] ready;
  logic [1:0]    gid;
  logic          busy;
  logic          tx;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  uart_tx_arbiter #(
    .SYSTEM_CLK    (16),
    .UART_BUAD_RATE(1),
    .NUM_REQ       (NR)
  ) dut (
    .i_sys_clk  (clk),
    .i_rst_n    (rst_n),
    .i_req_valid(valid),
    .i_req_data (data),
    .o_req_ready(ready),
    .o_grant_id (gid),
    .o_busy     (busy),
    .o_uart_tx  (tx)
  );

  // Waits (bounded) for a grant strobe; returns inside the grant cycle, 1ns after its negedge.
  task automatic wait_grant(input int max_cyc, output logic [NR-1:0] rdy, output logic timed_out);
    rdy = '0;
    timed_out = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      #1;
      if (|ready) begin
        rdy = ready;
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Samples the 160 frame cycles following a grant cycle at each negedge.
  task automatic capture_frame(output logic [9:0] frame, output logic steady,
                               output int busy_cnt, output logic ready_seen);
    frame = '0;
    steady = 1'b1;
    busy_cnt = 0;
    ready_seen = 1'b0;
    for (int k = 0; k < 10*DIV; k++) begin
      @(negedge clk);
      if (k % DIV == 0) frame[k/DIV] = tx;
      else if (tx !== frame[k/DIV]) steady = 1'b0;
      if (busy === 1'b1) busy_cnt++;
      if (|ready) ready_seen = 1'b1;
    end
  endtask

  // Waits (bounded) for the line to go idle after a frame.
  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_timeout: busy=%b required 0", name, busy);
    end
  endtask

  task automatic test_reset();
    logic [NR-1:0] r;
    rst_n = 1'b0;
    valid = 4'hF;
    data  = 32'h33221100;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (tx !== 1'b1)     begin errors++; $display("FAIL rst_tx: got %b want 1", tx); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (ready !== 4'h0)  begin errors++; $display("FAIL rst_ready: got %b want 0000", ready); end
    checks++; if (gid !== 2'd0)    begin errors++; $display("FAIL rst_gid: got %0d want 0", gid); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    r = ready;
    checks++; if (r !== 4'b0001)   begin errors++; $display("FAIL rst_first_grant: got %b want 0001", r); end
    @(posedge clk);
    #1;
    valid = '0;
    checks++; if (gid !== 2'd0)    begin errors++; $display("FAIL rst_first_gid: got %0d want 0", gid); end
    checks++; if (busy !== 1'b1 || tx !== 1'b0) begin
      errors++; $display("FAIL rst_first_frame: busy=%b tx=%b want busy=1 tx=0", busy, tx);
    end
    wait_idle("reset");
  endtask

  task automatic test_single_byte();
    logic [NR-1:0] r;
    logic to, st, rs;
    logic [9:0] fr;
    int bc;
    @(negedge clk);
    data[23:16] = 8'hA5;
    valid = 4'b0100;
    wait_grant(20, r, to);
    checks++; if (to || r !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b want 0100", r); end
    capture_frame(fr, st, bc, rs);
    valid = '0;
    checks++; if (gid !== 2'd2)      begin errors++; $display("FAIL single_gid: got %0d want 2", gid); end
    checks++; if (fr !== 10'b1_10100101_0) begin errors++; $display("FAIL single_frame: got %b want 1101001010", fr); end
    checks++; if (st !== 1'b1)       begin errors++; $display("FAIL single_bit_width: got unsteady bit levels, want 16-cycle levels"); end
    checks++; if (bc != 160)         begin errors++; $display("FAIL single_busy_len: got %0d want 160", bc); end
    checks++; if (rs !== 1'b0)       begin errors++; $display("FAIL single_ready_in_frame: got %b want 0", rs); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || tx !== 1'b1) begin
      errors++; $display("FAIL single_gap: busy=%b tx=%b want busy=0 tx=1", busy, tx);
    end
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] r;
    logic to, st, rs;
    logic [9:0] fr;
    logic [7:0] exp_b;
    int bc, t, prev;
    @(negedge clk);
    rst_n = 1'b0;
    valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    data  = 32'h33221100;
    valid = 4'hF;
    prev  = 0;
    for (int g = 0; g < 5; g++) begin
      wait_grant(200, r, to);
      t = cyc;
      checks++; if (to || r !== (4'b0001 << (g % 4))) begin
        errors++; $display("FAIL rr_order_%0d: got %b want %b", g, r, 4'b0001 << (g % 4));
      end
      if (g > 0) begin
        checks++; if (t - prev != 161) begin errors++; $display("FAIL rr_period_%0d: got %0d want 161", g, t - prev); end
      end
      prev = t;
      capture_frame(fr, st, bc, rs);
      exp_b = data[8*(g % 4) +: 8];
      checks++; if (fr !== {1'b1, exp_b, 1'b0} || st !== 1'b1) begin
        errors++; $display("FAIL rr_byte_%0d: got frame %b want %b", g, fr, {1'b1, exp_b, 1'b0});
      end
      checks++; if (gid !== 2'(g % 4)) begin errors++; $display("FAIL rr_gid_%0d: got %0d want %0d", g, gid, g % 4); end
    end
    valid = '0;
    wait_idle("rr");
  endtask

  task automatic test_withdrawal();
    logic [NR-1:0] r;
    logic to;
    @(negedge clk);
    rst_n = 1'b0;
    valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    data[7:0] = 8'h77;
    valid = 4'b0001;
    wait_grant(10, r, to);
    checks++; if (to || r !== 4'b0001) begin errors++; $display("FAIL wd_first: got %b want 0001", r); end
    @(posedge clk);
    #1;
    valid = 4'b1010;
    repeat (159) @(posedge clk);
    #1;
    valid[1] = 1'b0;
    checks++; if (busy !== 1'b1 || tx !== 1'b1) begin
      errors++; $display("FAIL wd_stop_bit: busy=%b tx=%b want busy=1 tx=1", busy, tx);
    end
    wait_grant(10, r, to);
    checks++; if (to || r !== 4'b1000) begin errors++; $display("FAIL wd_skip: got %b want 1000", r); end
    @(posedge clk);
    #1;
    valid = '0;
    checks++; if (gid !== 2'd3) begin errors++; $display("FAIL wd_gid: got %0d want 3", gid); end
    wait_idle("wd");
  endtask

  task automatic test_reset_mid_frame();
    logic [NR-1:0] r;
    logic to, st, rs;
    logic [9:0] fr;
    int bc;
    @(negedge clk);
    data[7:0] = 8'h00;
    valid = 4'b0001;
    wait_grant(10, r, to);
    checks++; if (to || r !== 4'b0001) begin errors++; $display("FAIL mid_grant: got %b want 0001", r); end
    @(posedge clk);
    #1;
    valid = '0;
    repeat (69) @(posedge clk);
    #1;
    checks++; if (tx !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL mid_bit3: tx=%b busy=%b want tx=0 busy=1", tx, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++; if (tx !== 1'b1)    begin errors++; $display("FAIL mid_rst_tx: got %b want 1", tx); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    data[7:0] = 8'h5A;
    valid = 4'b0001;
    wait_grant(10, r, to);
    checks++; if (to || r !== 4'b0001) begin errors++; $display("FAIL mid_regrant: got %b want 0001", r); end
    capture_frame(fr, st, bc, rs);
    valid = '0;
    checks++; if (fr !== 10'b1_01011010_0 || st !== 1'b1) begin
      errors++; $display("FAIL mid_new_frame: got %b want 1010110100", fr);
    end
    checks++; if (bc != 160) begin errors++; $display("FAIL mid_busy_len: got %0d want 160", bc); end
    wait_idle("mid");
  endtask

  task automatic test_data_hold();
    logic [NR-1:0] r;
    logic to, st, rs;
    logic [9:0] fr;
    int bc;
    @(negedge clk);
    data[15:8] = 8'h3C;
    valid = 4'b0010;
    wait_grant(10, r, to);
    checks++; if (to || r !== 4'b0010) begin errors++; $display("FAIL hold_grant: got %b want 0010", r); end
    @(posedge clk);
    #1;
    data[15:8] = 8'hFF;
    valid = '0;
    capture_frame(fr, st, bc, rs);
    checks++; if (fr !== 10'b1_00111100_0 || st !== 1'b1) begin
      errors++; $display("FAIL hold_byte: got %b want 1001111000", fr);
    end
    checks++; if (gid !== 2'd1) begin errors++; $display("FAIL hold_gid: got %0d want 1", gid); end
    wait_idle("hold");
  endtask

  initial begin
    rst_n = 1'b0;
    valid = '0;
    data  = '0;
    test_reset();
    test_single_byte();
    test_round_robin();
    test_withdrawal();
    test_reset_mid_frame();
    test_data_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one UART transmit line between `NUM_REQ` byte requesters. It contains its own baud-period counter derived from `SYSTEM_CLK/UART_BUAD_RATE`, grants one requester per frame, and serialises the granted byte as 8N1. It sits between multiple on-chip byte producers and the single `o_uart_tx` pin.

## Interface
- `SYSTEM_CLK`, 50000000, system clock frequency in Hz.
- `UART_BUAD_RATE`, 9600, line rate in baud.
- `NUM_REQ`, 4, number of requesters, range 2..16.
- `DIVIDER = SYSTEM_CLK/UART_BUAD_RATE` (localparam, integer division), must be ≥ 2.
- `ID_W = $clog2(NUM_REQ)` (localparam).

Ports:
- `i_sys_clk`  in  1  system clock, rising edge.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_req_valid`  in  NUM_REQ  per-requester byte-valid; held until granted.
- `i_req_data`  in  NUM_REQ*8  byte of requester k at `[8k+7:8k]`.
- `o_req_ready`  out  NUM_REQ  one-hot grant/accept strobe (combinational).
- `o_grant_id`  out  ID_W  index of the requester owning the current or last frame.
- `o_busy`  out  1  frame in progress.
- `o_uart_tx`  out  1  serial line, idle high.

## Operation
- States are IDLE, START, DATA, and STOP.
- **IDLE**
  - `o_uart_tx`=1 and `o_busy`=0.
  - If any `i_req_valid` bit is set, select the winner: the first set bit scanning from `last_grant+1` upward, wrapping modulo `NUM_REQ`.
  - Assert `o_req_ready[winner]`=1 this cycle only.
  - On that edge:
    - latch the byte into the shift register;
    - set `last_grant` and `o_grant_id` to the winner;
    - clear the baud counter;
    - go to START.
- **START**: `o_uart_tx`=0 for `DIVIDER` cycles, then go to DATA with bit index 0.
- **DATA**
  - `o_uart_tx` carries shift-register bit[idx], LSB first. Each bit lasts `DIVIDER` cycles.
  - After bit 7, go to STOP.
- **STOP**: `o_uart_tx`=1 for `DIVIDER` cycles, then go to IDLE.
- **Baud counter**
  - Counts 0..`DIVIDER-1` and wraps.
  - The bit-end tick fires when count equals `DIVIDER-1`.
  - Width is `$clog2(DIVIDER)`.
  - The counter runs only outside IDLE.
- **Handshake**
  - Transfer occurs on a cycle with `i_req_valid[k] & o_req_ready[k]`.
  - `o_req_ready` is never asserted outside IDLE.
  - `o_req_ready` is never asserted for more than one requester at a time.
  - `o_req_ready` is never asserted for a requester whose valid is low.
- **Withdrawal**: a requester dropping valid before its grant is simply skipped. Changes on `i_req_valid`/`i_req_data` during a frame have no effect.
- **Simultaneous requests**: the rotation is strict. With all requesters valid, grants go 0,1,…,NUM_REQ-1,0,…
- **Single requester**: a lone, continuously valid requester is granted on every IDLE visit.

## Timing
- **Reset values**:
  - `o_uart_tx`=1, `o_busy`=0, `o_req_ready`=0, `o_grant_id`=0;
  - `last_grant`=NUM_REQ-1, so requester 0 has first priority;
  - state = IDLE, counters = 0.
- **Reset mid-frame**: the line returns high asynchronously and the frame is aborted. The aborted byte is not retransmitted.
- **Grant timing**:
  - The grant is at cycle T.
  - `o_uart_tx` falls at T+1 and `o_busy` rises at T+1. Both `o_uart_tx` and `o_busy` are registered.
- **Frame length**: 10·`DIVIDER` cycles of `o_busy`=1, from T+1 to T+10·DIVIDER. The last stop-bit cycle is T+10·DIVIDER.
- **Back-to-back frames**:
  - IDLE always lasts at least 1 cycle, so the inter-frame gap is exactly 1 extra high cycle.
  - Frame period under continuous demand is 10·DIVIDER+1 cycles.
- **Grant latency**: from valid rising in IDLE, the grant occurs in the same cycle. Worst-case wait is (NUM_REQ-1)·(10·DIVIDER+1) cycles plus the remainder of the current frame.

## Test plan
Bench configuration: `SYSTEM_CLK`=16, `UART_BUAD_RATE`=1 (so `DIVIDER`=16), `NUM_REQ`=4.

1. **Reset**: hold `i_rst_n`=0 with all valids high. Required: `o_uart_tx`=1, `o_busy`=0, `o_req_ready`=0. After release, the first grant is `o_req_ready`=4'b0001 in the next IDLE cycle.
2. **Single byte**: req 2 sends 0xA5. Required:
   - `o_req_ready`=4'b0100 for 1 cycle and `o_grant_id`=2;
   - line sequence 0,1,0,1,0,0,1,0,1,1, each level lasting 16 cycles;
   - `o_busy` high for exactly 160 cycles.
3. **Round-robin**: all 4 requesters valid continuously with bytes 0x00/0x11/0x22/0x33. Required:
   - grant order 0,1,2,3,0;
   - frame period 161 cycles;
   - each decoded byte matches its requester.
4. **Withdrawal and skip**: req 1 and req 3 valid with `last_grant`=0; req 1 drops valid one cycle before IDLE. Required: req 3 is granted and req 1 never sees ready.
5. **Reset mid-frame**: assert `i_rst_n`=0 during DATA bit 3. Required:
   - line is high within the same cycle;
   - `o_busy`=0;
   - after release, a new request from req 0 produces a complete, correct frame.
6. **Data hold**: change `i_req_data` of the granted requester during the frame. Required: the transmitted byte equals the value latched at grant.
